reg_file: RTL

//  LEGv8 register file, X0..X31: the receiving end of the write-back interface (RegWrite, w_reg, w_data).
//  Two combinational read ports feed ID operand fetch.

---
 rtl/reg_file_pkg.sv | 22 ++
 rtl/reg_file_if.sv | 42 ++++
 rtl/reg_file_scoreboard.sv | 61 ++++++
 rtl/reg_file.sv | 57 +++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared sizing constants and helpers for the LEGv8 register file and its load scoreboard.
// Optional build macro used by this slice: REG_BYPASS_EN (write-through bypass).
package reg_file_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned CNT_W    = 6;

  localparam logic [ADDR_W-1:0] XZR = 5'd31;

  // Number of set bits; CNT_W holds up to NUM_REGS so the sum cannot wrap.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Operand-fetch, write-back and load-issue signals between the pipeline and the register file.
// Optional build macro affecting the slave side: REG_BYPASS_EN.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int unsigned P_DATA_W = DATA_W,
  parameter int unsigned P_ADDR_W = ADDR_W,
  parameter int unsigned P_CNT_W  = CNT_W
);

  // No valid/ready pair here: RegWrite and pend_set are single-cycle strobes
  // sampled at every rising clock edge, and the register file can never refuse
  // them; stall is the only back-pressure and it goes to the ID stage.
  logic [P_ADDR_W-1:0] r_reg1;
  logic [P_ADDR_W-1:0] r_reg2;
  logic                r1_used;
  logic                r2_used;
  logic [P_DATA_W-1:0] r_data1;
  logic [P_DATA_W-1:0] r_data2;
  logic                RegWrite;
  logic [P_ADDR_W-1:0] w_reg;
  logic [P_DATA_W-1:0] w_data;
  logic                pend_set;
  logic [P_ADDR_W-1:0] pend_reg;
  logic                stall;
  logic [P_CNT_W-1:0]  pend_cnt;

  modport master (
    output r_reg1, r_reg2, r1_used, r2_used,
    output RegWrite, w_reg, w_data,
    output pend_set, pend_reg,
    input  r_data1, r_data2, stall, pend_cnt
  );

  modport slave (
    input  r_reg1, r_reg2, r1_used, r2_used,
    input  RegWrite, w_reg, w_data,
    input  pend_set, pend_reg,
    output r_data1, r_data2, stall, pend_cnt
  );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Load scoreboard: one pending bit per register, set at load issue, cleared at write-back.
// With REG_BYPASS_EN a pending bit cleared by the same-cycle write-back does not stall.
module reg_scoreboard
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] r_reg1,
  input  logic [ADDR_W-1:0] r_reg2,
  input  logic              r1_used,
  input  logic              r2_used,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] w_reg,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_reg,
  output logic              stall,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic [NUM_REGS-1:0] pend
);

  logic [NUM_REGS-1:0] pend_next;
  logic                hit1;
  logic                hit2;

  // Set is applied after clear so a newer load to the same register stays outstanding.
  always_comb begin
    pend_next = pend;
    if (wr_en && (w_reg != XZR)) begin
      pend_next[w_reg] = 1'b0;
    end
    if (pend_set && (pend_reg != XZR)) begin
      pend_next[pend_reg] = 1'b1;
    end
    pend_next[XZR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_next;
      pend_cnt <= popcount(pend_next);
    end
  end

  always_comb begin
    hit1 = pend[r_reg1];
    hit2 = pend[r_reg2];
`ifdef REG_BYPASS_EN
    if (wr_en && (w_reg != XZR) && (w_reg == r_reg1)) begin
      hit1 = 1'b0;
    end
    if (wr_en && (w_reg != XZR) && (w_reg == r_reg2)) begin
      hit2 = 1'b0;
    end
`endif
    stall = (r1_used & hit1) | (r2_used & hit2);
  end

endmodule

// File: rtl/reg_file.sv
// LEGv8 register file X0..X31 with two combinational read ports, write-back port and load scoreboard.
// Build macro REG_BYPASS_EN enables write-through bypass from the write-back port to the read ports.
module reg_file
  import reg_file_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  reg_file_if.slave    bus,
  output logic [NUM_REGS-1:0] pend_dbg
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = bus.RegWrite && (bus.w_reg != XZR);

  // Entry 31 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.w_reg] <= bus.w_data;
    end
  end

  always_comb begin
    bus.r_data1 = (bus.r_reg1 == XZR) ? '0 : regs[bus.r_reg1];
    bus.r_data2 = (bus.r_reg2 == XZR) ? '0 : regs[bus.r_reg2];
`ifdef REG_BYPASS_EN
    if (wr_ok && (bus.w_reg == bus.r_reg1)) begin
      bus.r_data1 = bus.w_data;
    end
    if (wr_ok && (bus.w_reg == bus.r_reg2)) begin
      bus.r_data2 = bus.w_data;
    end
`endif
  end

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_reg1   (bus.r_reg1),
    .r_reg2   (bus.r_reg2),
    .r1_used  (bus.r1_used),
    .r2_used  (bus.r2_used),
    .wr_en    (bus.RegWrite),
    .w_reg    (bus.w_reg),
    .pend_set (bus.pend_set),
    .pend_reg (bus.pend_reg),
    .stall    (bus.stall),
    .pend_cnt (bus.pend_cnt),
    .pend     (pend_dbg)
  );

endmodule
